// File: rtl/tdm_pkg.sv
// Shared definitions for both ends of the 4-slot TDM link: slot count,
// receiver FSM encoding and slot index constants.
package tdm_pkg;

  localparam int NSLOT  = 4;
  localparam int SLOT_W = 2;

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [SLOT_W-1:0] SLOT0 = 2'd0;
  localparam logic [SLOT_W-1:0] SLOT1 = 2'd1;
  localparam logic [SLOT_W-1:0] SLOT2 = 2'd2;
  localparam logic [SLOT_W-1:0] SLOT3 = 2'd3;

  function automatic logic [SLOT_W-1:0] slot_inc(input logic [SLOT_W-1:0] s);
    return (s == SLOT3) ? SLOT0 : s + 2'd1;
  endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot index counter shared by the TX sequencer and RX demux: a sync
// realigns to slot 1, an accept advances with 3->0 wrap.
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              inc,
  output logic [SLOT_W-1:0] slot
);

  logic [SLOT_W-1:0] slot_r;

  // Load has priority so a sync always realigns, even mid-frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_r <= SLOT0;
    end else if (load) begin
      slot_r <= SLOT1;
    end else if (inc) begin
      slot_r <= slot_inc(slot_r);
    end else begin
      slot_r <= slot_r;
    end
  end

  assign slot = slot_r;

endmodule

// File: rtl/demux_4to1_tdm_rx.sv
// Receive side of the 4-slot TDM link: aligns to sync, collects slots into
// shadow registers and hands out complete frames over valid/ready.
module demux_4to1_tdm_rx
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int NSLOT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   din,
  input  logic               din_valid,
  input  logic               sync,
  output logic [NSLOT*WIDTH-1:0] frame,
  output logic               frame_valid,
  input  logic               frame_ready,
  output logic [SLOT_W-1:0]  slot,
  output logic               locked,
  output logic               sync_err,
  output logic               overrun
);

  state_t                   state_r;
  state_t                   state_next_s;
  logic [SLOT_W-1:0]        slot_s;
  logic                     load_s;
  logic                     inc_s;
  logic                     complete_s;
  logic                     misalign_s;
  logic                     out_free_s;
  logic [WIDTH-1:0]         shadow_r [0:NSLOT-2];
  logic [NSLOT*WIDTH-1:0]   frame_next_s;
  logic [NSLOT*WIDTH-1:0]   frame_r;
  logic                     frame_valid_r;
  logic                     sync_err_r;
  logic                     overrun_r;

  tdm_slot_ctr u_slot_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_s),
    .inc   (inc_s),
    .slot  (slot_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_HUNT;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state: once aligned, resyncs are handled in RUN.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_HUNT: state_next_s = (din_valid & sync) ? ST_RUN : ST_HUNT;
      ST_RUN:  state_next_s = ST_RUN;
      default: state_next_s = ST_HUNT;
    endcase
  end

  // FSM outputs: per-accept datapath actions.
  always_comb begin
    load_s     = 1'b0;
    inc_s      = 1'b0;
    complete_s = 1'b0;
    misalign_s = 1'b0;
    case (state_r)
      ST_HUNT: begin
        load_s = din_valid & sync;
      end
      ST_RUN: begin
        load_s     = din_valid & sync;
        inc_s      = din_valid & ~sync;
        complete_s = din_valid & ~sync & (slot_s == SLOT3);
        misalign_s = din_valid & sync & (slot_s != SLOT0);
      end
      default: begin
        load_s     = 1'b0;
        inc_s      = 1'b0;
        complete_s = 1'b0;
        misalign_s = 1'b0;
      end
    endcase
  end

  // Shadow registers for slots 0..NSLOT-2; the last slot goes straight to the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSLOT-1; k++) begin
        shadow_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NSLOT-1; k++) begin
        if (load_s && (k == 0)) begin
          shadow_r[k] <= din;
        end else if (inc_s && (slot_s == SLOT_W'(k))) begin
          shadow_r[k] <= din;
        end else begin
          shadow_r[k] <= shadow_r[k];
        end
      end
    end
  end

  // Assemble the completed frame from the shadows plus the current sample.
  always_comb begin
    frame_next_s = '0;
    for (int k = 0; k < NSLOT-1; k++) begin
      frame_next_s[WIDTH*k +: WIDTH] = shadow_r[k];
    end
    frame_next_s[WIDTH*(NSLOT-1) +: WIDTH] = din;
  end

  assign out_free_s = ~frame_valid_r | frame_ready;

  // Output register and handshake; a consume and refill may share one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_r       <= '0;
      frame_valid_r <= 1'b0;
    end else if (complete_s && out_free_s) begin
      frame_r       <= frame_next_s;
      frame_valid_r <= 1'b1;
    end else if (frame_valid_r && frame_ready) begin
      frame_r       <= frame_r;
      frame_valid_r <= 1'b0;
    end else begin
      frame_r       <= frame_r;
      frame_valid_r <= frame_valid_r;
    end
  end

  // Single-cycle event pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_err_r <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      sync_err_r <= misalign_s;
      overrun_r  <= complete_s & ~out_free_s;
    end
  end

  assign frame       = frame_r;
  assign frame_valid = frame_valid_r;
  assign slot        = slot_s;
  assign locked      = (state_r == ST_RUN);
  assign sync_err    = sync_err_r;
  assign overrun     = overrun_r;

endmodule
